cnn_frame_loader: RTL

Writer-side front end for the CNN input image memory; replaces file preload with a live pixel stream.
- Accepts signed 32-bit pixels over a valid/ready stream, row-major, and stores them into frame buffer bank(s).
- Flags a complete frame to the conv scanner.
- Serves registered 5x5 windows addressed by the scanner's (win_x, win_y) counters.
- Frame is freed when the consumer pulses release.

---
 rtl/cnn_frame_loader_if.sv | 14 +
 rtl/cnn_frame_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/cnn_frame_loader_if.sv
// cnn_frame_loader_if: pixel stream into the CNN frame loader.
// Ports: s_valid/s_data/s_last are driven by the producer; s_ready is returned by the loader.
// Modports: master (pixel source), slave (loader).
interface cnn_frame_loader_if #(
  parameter int PIX_W = 32
);
  logic             s_valid;
  logic [PIX_W-1:0] s_data;
  logic             s_last;
  logic             s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/cnn_frame_loader.sv
// cnn_frame_loader: writer-side front end for the CNN input image memory.
// Latency: pixel written on its transfer; frame_valid rises 2 cycles after the last
// pixel; win_data is registered (1 cycle after win_x/win_y). Backpressure: s_ready drops
// in STALL while no free bank exists; the stream resumes once frame_release frees one.
// Ports: clk/rst (sync, active-high); s_if (slave pixel stream with s_last);
//   win_x/win_y -> win_data (5x5 window, out-of-image elements read 0);
//   frame_valid/frame_release (read-side frame hand-off); frame_err (s_last position error);
//   pix_count (pixels accepted into the current write frame).
// Build option: define CNN_LOADER_PINGPONG_EN for two banks (load next frame while the
//   current one is consumed); undefined, a single bank is used and wr/rd bank stay 0.
module cnn_frame_loader #(
  parameter int IMG_H = 28,
  parameter int IMG_W = 28,
  parameter int PIX_W = 32,
  parameter int WIN   = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  cnn_frame_loader_if.slave        s_if,
  input  logic [4:0]               win_x,
  input  logic [4:0]               win_y,
  output logic [WIN*WIN*PIX_W-1:0] win_data,
  output logic                     frame_valid,
  input  logic                     frame_release,
  output logic                     frame_err,
  output logic [9:0]               pix_count
);
  localparam int FRAME = IMG_H * IMG_W;
  localparam int XW    = $clog2(IMG_H);
  localparam int YW    = $clog2(IMG_W);

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} wr_state_e;

  wr_state_e                state_q, state_d;
  logic [1:0]               full_q, full_d;
  logic                     wr_bank_q, wr_bank_d;
  logic                     rd_bank_q, rd_bank_d;
  logic [9:0]               pix_count_q, pix_count_d;
  logic [XW-1:0]            wr_row_q, wr_row_d;
  logic [YW-1:0]            wr_col_q, wr_col_d;
  logic                     frame_valid_q, frame_valid_d;
  logic                     frame_err_q, frame_err_d;
  logic                     late_err_q, late_err_d;
  logic [WIN*WIN*PIX_W-1:0] win_data_q, win_data_d;

  // Image storage; deliberately not reset.
  logic [PIX_W-1:0] mem_q [2][IMG_H][IMG_W];

  logic       xfer;
  logic       rel;
  logic       early_err;
  logic [5:0] row;
  logic [5:0] col;

  assign s_if.s_ready = (state_q == FILL);
  assign xfer         = s_if.s_valid && s_if.s_ready;
  // A release only counts while a frame is actually presented.
  assign rel          = frame_release && frame_valid_q;

  always_comb begin
    state_d     = state_q;
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    pix_count_d = pix_count_q;
    wr_row_d    = wr_row_q;
    wr_col_d    = wr_col_q;
    late_err_d  = 1'b0;
    early_err   = 1'b0;

    // Release is applied before completion so a frame finishing in the same cycle
    // already sees the freed bank.
    if (rel) begin
      full_d[rd_bank_q] = 1'b0;
`ifdef CNN_LOADER_PINGPONG_EN
      rd_bank_d = ~rd_bank_q;
`endif
    end

    case (state_q)
      FILL: begin
        if (xfer) begin
          if (pix_count_q == 10'(FRAME - 1)) begin
            full_d[wr_bank_q] = 1'b1;
            pix_count_d       = '0;
            wr_row_d          = '0;
            wr_col_d          = '0;
            late_err_d        = !s_if.s_last;
`ifdef CNN_LOADER_PINGPONG_EN
            if (!full_d[~wr_bank_q]) wr_bank_d = ~wr_bank_q;
            else                     state_d   = STALL;
`else
            state_d = STALL;
`endif
          end else if (s_if.s_last) begin
            // Early s_last: drop the partial frame and restart at pixel 0.
            pix_count_d = '0;
            wr_row_d    = '0;
            wr_col_d    = '0;
            early_err   = 1'b1;
          end else begin
            pix_count_d = pix_count_q + 10'd1;
            if (wr_col_q == YW'(IMG_W - 1)) begin
              wr_col_d = '0;
              wr_row_d = wr_row_q + XW'(1);
            end else begin
              wr_col_d = wr_col_q + YW'(1);
            end
          end
        end
      end
      STALL: begin
`ifdef CNN_LOADER_PINGPONG_EN
        if (!full_q[~wr_bank_q]) begin
          wr_bank_d = ~wr_bank_q;
          state_d   = FILL;
        end
`else
        if (!full_q[0]) state_d = FILL;
`endif
      end
    endcase

    // Dropped for the cycle after a release so a held release cannot free two frames.
    frame_valid_d = full_q[rd_bank_q] && !rel;
    // A missing s_last is reported one cycle later so it coincides with frame_valid rising.
    frame_err_d   = early_err || late_err_q;
  end

  // Registered 5x5 window from the read bank; elements outside the image read as 0.
  always_comb begin
    win_data_d = '0;
    row        = '0;
    col        = '0;
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        row = {1'b0, win_x} + 6'(r);
        col = {1'b0, win_y} + 6'(c);
        if (row < 6'(IMG_H) && col < 6'(IMG_W))
          win_data_d[(r*WIN+c)*PIX_W +: PIX_W] = mem_q[rd_bank_q][row[XW-1:0]][col[YW-1:0]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FILL;
      full_q        <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      pix_count_q   <= '0;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      late_err_q    <= 1'b0;
      win_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      full_q        <= full_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      pix_count_q   <= pix_count_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      late_err_q    <= late_err_d;
      win_data_q    <= win_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (xfer && !rst) mem_q[wr_bank_q][wr_row_q][wr_col_q] <= s_if.s_data;
  end

  assign win_data    = win_data_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign pix_count   = pix_count_q;
endmodule
